// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle (ovf under SERIAL_SUB_SIGNED_OVF_EN)
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    // Sequencer side: issues operands and start, observes status and result
    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        input  ovf,
`endif
        input  busy, done, result, borrow_out
    );

    // Subtractor side
    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        output ovf,
`endif
        output busy, done, result, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full-subtractor cell
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out of x - y - bin
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial unsigned subtractor (optional ovf via SERIAL_SUB_SIGNED_OVF_EN)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   result_q;
    logic               brw;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt;
    logic               d;
    logic               brw_n;
    logic               load;
    logic               last;
    logic               busy_c;
    logic               done_c;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic               a_sgn;
    logic               b_sgn;
    logic               ovf_q;
`endif

    full_subtractor u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (d),
        .bout (brw_n)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state; busy/done depend on the registered state only
    always_comb begin
        state_n = state;
        load    = 1'b0;
        last    = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, borrow chain, bit counter and result accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            result_q <= '0;
            brw      <= 1'b0;
            borrow_q <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_sgn    <= 1'b0;
            b_sgn    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (load) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            result_q <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_sgn    <= bus.a[WIDTH-1];
            b_sgn    <= bus.b[WIDTH-1];
`endif
        end else if (state == ST_RUN) begin
            result_q <= {d, result_q[WIDTH-1:1]};
            a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
            brw      <= brw_n;
            cnt      <= cnt + CNT_W'(1);
            if (last) begin
                borrow_q <= brw_n;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                // d is the result sign bit on the final step
                ovf_q    <= (a_sgn != b_sgn) && (d != a_sgn);
`endif
            end
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.result     = result_q;
    assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   tests    = 0;
    int   failed   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.r  = x - y;
        e.bo = (x < y);
        e.ov = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        if (push) sb.push_back(model(x, y));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, output int done_at);
        int   n    = 0;
        bit   seen = 1'b0;
        exp_t e;
        done_at = -1;
        for (int i = 1; i <= W + 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        done_at = cyc;
        if (exp_lat > 0) chk({tag, " latency"}, n, exp_lat);
        chk({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, " result"}, 32'(bus.result), 32'(e.r));
        chk({tag, " borrow"}, 32'(bus.borrow_out), 32'(e.bo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk({tag, " ovf"}, 32'(bus.ovf), 32'(e.ov));
`endif
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int t0, t1, t2, d0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst result", 32'(bus.result), 32'd0);
        chk("rst borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("rst ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        start_op(8'd5, 8'd3, 1'b1);
        chk("run busy", 32'(bus.busy), 32'd1);
        wait_done("5-3", W, t0);
        start_op(8'd3, 8'd5, 1'b1);
        wait_done("3-5", W, t0);
        start_op(8'h80, 8'h01, 1'b1);
        wait_done("80-01", W, t0);
        start_op(8'd0, 8'd0, 1'b1);
        wait_done("0-0", W, t0);
        start_op(8'd0, 8'd1, 1'b1);
        wait_done("0-1", W, t0);
        start_op(8'h7F, 8'hFF, 1'b1);
        wait_done("7f-ff", W, t0);

        // start pulsed mid-run must be ignored
        d0 = done_cnt;
        start_op(8'd9, 8'd4, 1'b1);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore", W - 3, t0);
        repeat (W + 4) @(negedge clk);
        chk("ignore done_pulses", done_cnt - d0, 1);
        chk("ignore idle", 32'(bus.busy), 32'd0);

        // asynchronous abort in the middle of RUN
        d0 = done_cnt;
        start_op(8'd100, 8'd50, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort result", 32'(bus.result), 32'd0);
        chk("abort borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("abort ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("abort no_done", done_cnt - d0, 0);
        start_op(8'd7, 8'd2, 1'b1);
        wait_done("after_abort", W, t0);

        // start held high: accepted on every IDLE cycle
        bus.a     = 8'd200;
        bus.b     = 8'd100;
        bus.start = 1'b1;
        repeat (3) sb.push_back(model(8'd200, 8'd100));
        wait_done("b2b0", W + 1, t0);
        wait_done("b2b1", W + 1, t1);
        chk("b2b period1", t1 - t0, W + 2);
        wait_done("b2b2", W + 1, t2);
        bus.start = 1'b0;
        chk("b2b period2", t2 - t1, W + 2);

        repeat (W + 4) @(negedge clk);
        chk("final idle", 32'(bus.busy), 32'd0);
        chk("sb drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
